// File: rtl/light_shade_scheduler.sv
// rtl/light_shade_scheduler.sv - per-triangle light loop through the light_intensity pipe
// Issues one light per cycle blind, accumulates the tagged returns, saturates to 1.0 and culls on light 0.
module light_shade_scheduler #(
  parameter int NORM_WIDTH = 16,
  parameter int NORM_FRAC  = 14,
  parameter int MAX_LIGHTS = 4,
  parameter int ID_WIDTH   = 12,
  parameter int LI_LATENCY = 4
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  cfg_we_in,
  input  logic [((MAX_LIGHTS > 1) ? $clog2(MAX_LIGHTS) : 1)-1:0] cfg_addr_in,
  input  logic [3*NORM_WIDTH-1:0]               cfg_norm_in,
  input  logic [$clog2(MAX_LIGHTS):0]           num_lights_in,
  input  logic                                  tri_valid_in,
  output logic                                  tri_ready_out,
  input  logic [3*NORM_WIDTH-1:0]               tri_norm_in,
  input  logic [ID_WIDTH-1:0]                   tri_id_in,
  output logic [3*NORM_WIDTH-1:0]               li_tri_norm_out,
  output logic [3*NORM_WIDTH-1:0]               li_cam_norm_out,
  input  logic [NORM_WIDTH-1:0]                 li_intensity_in,
  input  logic                                  li_facing_in,
  output logic                                  shade_valid_out,
  input  logic                                  shade_ready_in,
  output logic [NORM_WIDTH-1:0]                 shade_intensity_out,
  output logic                                  shade_visible_out,
  output logic [ID_WIDTH-1:0]                   shade_id_out
);
  localparam int AW   = (MAX_LIGHTS > 1) ? $clog2(MAX_LIGHTS) : 1;
  localparam int CW   = $clog2(MAX_LIGHTS) + 1;
  localparam int ACCW = NORM_WIDTH + $clog2(MAX_LIGHTS) + 1;
  localparam logic signed [ACCW-1:0] ONE = ACCW'(1 << NORM_FRAC);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t                   state;
  logic [3*NORM_WIDTH-1:0]  light_tbl [MAX_LIGHTS];
  logic [ID_WIDTH-1:0]      id_q;
  logic [CW-1:0]            n_q, k_q, n_sel, next_k;
  logic [LI_LATENCY-1:0]    tag_v, tag_f, tag_l;
  logic signed [ACCW-1:0]   acc, addend, sum;
  logic                     vis_q, fin_vis, accept, ret;
  logic                     push_v, push_f, push_l;
  logic [AW-1:0]            issue_idx;
  logic [NORM_WIDTH-1:0]    fin_int;

  always_comb begin
    n_sel = num_lights_in;
    if (num_lights_in == '0)
      n_sel = CW'(1);
    else if (num_lights_in > CW'(MAX_LIGHTS))
      n_sel = CW'(MAX_LIGHTS);
  end

  // Tag bits travel alongside each issue so only our own returns are consumed.
  always_comb begin
    accept    = tri_ready_out & tri_valid_in;
    next_k    = k_q + CW'(1);
    push_v    = 1'b0;
    push_f    = 1'b0;
    push_l    = 1'b0;
    issue_idx = next_k[AW-1:0];
    if (accept) begin
      push_v    = 1'b1;
      push_f    = 1'b1;
      push_l    = (n_sel == CW'(1));
      issue_idx = '0;
    end else if (state == ISSUE && k_q != n_q - CW'(1)) begin
      push_v = 1'b1;
      push_l = (next_k == n_q - CW'(1));
    end
  end

  always_comb begin
    ret     = tag_v[LI_LATENCY-1];
    addend  = li_facing_in ? {{(ACCW-NORM_WIDTH){li_intensity_in[NORM_WIDTH-1]}}, li_intensity_in} : '0;
    sum     = acc + addend;
    fin_int = (sum > ONE) ? ONE[NORM_WIDTH-1:0] : sum[NORM_WIDTH-1:0];
    fin_vis = tag_f[LI_LATENCY-1] ? li_facing_in : vis_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state               <= IDLE;
      tri_ready_out       <= 1'b1;
      shade_valid_out     <= 1'b0;
      shade_intensity_out <= '0;
      shade_visible_out   <= 1'b0;
      shade_id_out        <= '0;
      li_tri_norm_out     <= '0;
      li_cam_norm_out     <= '0;
      for (int i = 0; i < MAX_LIGHTS; i++) light_tbl[i] <= '0;
      id_q  <= '0;
      n_q   <= '0;
      k_q   <= '0;
      tag_v <= '0;
      tag_f <= '0;
      tag_l <= '0;
      acc   <= '0;
      vis_q <= 1'b0;
    end else begin
      if (cfg_we_in && (AW+1)'(cfg_addr_in) < (AW+1)'(MAX_LIGHTS))
        light_tbl[cfg_addr_in] <= cfg_norm_in;

      tag_v <= {tag_v[LI_LATENCY-2:0], push_v};
      tag_f <= {tag_f[LI_LATENCY-2:0], push_f};
      tag_l <= {tag_l[LI_LATENCY-2:0], push_l};
      if (push_v) li_cam_norm_out <= light_tbl[issue_idx];

      if (ret) acc <= sum;
      if (ret && tag_f[LI_LATENCY-1]) vis_q <= li_facing_in;

      case (state)
        IDLE: if (accept) begin
          li_tri_norm_out <= tri_norm_in;
          id_q            <= tri_id_in;
          n_q             <= n_sel;
          k_q             <= '0;
          acc             <= '0;
          tri_ready_out   <= 1'b0;
          state           <= ISSUE;
        end
        ISSUE: begin
          if (k_q == n_q - CW'(1)) state <= WAIT;
          else                     k_q   <= next_k;
        end
        WAIT: if (ret && tag_l[LI_LATENCY-1]) begin
          shade_valid_out     <= 1'b1;
          shade_intensity_out <= fin_int;
          shade_visible_out   <= fin_vis;
          shade_id_out        <= id_q;
          state               <= OUT;
        end
        OUT: if (shade_ready_in) begin
          shade_valid_out <= 1'b0;
          tri_ready_out   <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
